dlx_data_mem: RTL and testbench
===============================

Name: dlx_data_mem

Overview:
- Data-memory responder for the pipelined DLX core. It sits on the far end of the core's MEM-stage bus: mem_addr, mem_write_data, mem_wr, mem_sb/sh/lb/lh in; mem_read_data out.
- Loads are answered combinationally in the same cycle, because the core captures read data at the MEM/WB edge.
- Stores are posted into a small store queue that drains into a word array. A testbench preload port shares the array write port and has priority.

Parameters:
- ADDR_WIDTH, 10, word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- STQ_DEPTH, 4, store-queue entries; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_addr  in  32  byte address from the core
- mem_write_data  in  32  store data; sub-word data is right-justified
- mem_wr  in  1  store strobe, sampled on the clk edge
- mem_sb  in  1  byte store
- mem_sh  in  1  halfword store
- mem_lb  in  1  byte load
- mem_lh  in  1  halfword load
- mem_read_data  out  32  load data (combinational)
- init_wr  in  1  preload write; has priority on the array port
- init_addr  in  ADDR_WIDTH  preload word address
- init_data  in  32  preload word
- stq_count  out  3  number of occupied queue entries
- mem_err  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and reset.
- Addressing:
  - Word index = mem_addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap.
  - Byte order is big-endian: byte offset 0 is bits [31:24], offset 3 is bits [7:0].
- Store lane formation:
  - sb: data[7:0] goes to lane mem_addr[1:0]; enable is a 1-hot 4-bit mask.
  - sh: data[15:0] goes to half mem_addr[1] (offset 0 = [31:16]); enable 1100 or 0011.
  - Word store: all four lanes, enable 1111.
  - Misalignment:
    - sh with mem_addr[0]=1 is treated as aligned (bit 0 ignored) and sets mem_err.
    - A word access with mem_addr[1:0]!=0 is treated as aligned (low bits ignored) and sets mem_err.
- Store queue (FIFO of {word_index, lane_data, byte_en}):
  - On a clk edge with mem_wr=1 and the queue not full, the store is enqueued.
  - Drain: on each edge with init_wr=0 and the queue non-empty, the head entry is written to the array under its byte enables and dequeued.
  - Enqueue and dequeue in the same cycle are allowed; count is unchanged.
  - Full queue, mem_wr=1 and init_wr=0: dequeue and enqueue in the same edge; no loss.
  - Full queue, mem_wr=1 and init_wr=1: the store is dropped, mem_err is set, and the queue is unchanged.
  - init_wr=1 writes init_data to array[init_addr] that edge and blocks the drain.
- Load path:
  - Merged word = array word, overlaid by every valid queue entry with a matching word_index, oldest to youngest, per byte enable. The youngest write wins per lane.
  - mem_read_data output:
    - mem_lb: {24'b0, selected byte}.
    - mem_lh: {16'b0, selected half}.
    - otherwise: the merged word.
  - Sign extension is not done here; it is write-back's job.
  - mem_read_data is valid whenever mem_wr=0. Its value during mem_wr=1 cycles is don't-care.
- Reset:
  - The queue is emptied and pending stores are discarded.
  - stq_count=0 and mem_err=0.
  - Array contents are not reset.
  - Reset asserted mid-drain: no array write occurs on that edge; reset wins over drain and enqueue.
- mem_err clears only on reset.
- stq_count is registered and reflects occupancy after each edge.

Optional Feature:
- Macro: DMEM_STQ_EN.
- Defined: store queue and forwarding behave as described above.
- Undefined:
  - No queue; stq_count is tied to 0.
  - A store writes the array directly on its edge.
  - If init_wr=1 on the same edge, the preload write wins, the store is dropped and mem_err is set.
  - Loads read the array only.

Test Plan:
1. Preload: init_wr word 0x11223344 at index 5. Then lb at byte addr 0x16 -> mem_read_data=0x00000033; lh at 0x14 -> 0x00001122.
2. sb 0xAB at 0x15, then load the word at 0x14 on the next cycle, before the drain -> 0x11AB3344 via forwarding. The same value must remain after the drain, and stq_count returns 0.
3. With init_wr held high, issue 4 stores (sw 0x0 <- 1, 2, 3, 4) -> stq_count=4 and a word load at 0x0 returns 4. A 5th store -> mem_err=1 and stq_count stays 4. Release init_wr: the array word at 0 is 4 after 4 cycles.
4. Same-cycle full queue with init_wr=0 plus a store -> count stays 4 and no error.
5. Misaligned sh at 0x21 -> written to lanes [31:16] of index 8 and mem_err=1. Then reset -> mem_err=0, stq_count=0, and the array is unchanged.
6. Address wrap: sw 0xDEADBEEF at byte addr 4·2^ADDR_WIDTH + 8 (0x1008 at default) -> a load at 0x8 returns 0xDEADBEEF.

Source files
------------

// File: rtl/dlx_data_mem.sv
// rtl/dlx_data_mem.sv - DLX data memory: combinational loads, posted stores, testbench preload port.
// Optional store queue with load forwarding is built when DMEM_STQ_EN is defined.
module dlx_data_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int STQ_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_write_data,
  input  logic                  mem_wr,
  input  logic                  mem_sb,
  input  logic                  mem_sh,
  input  logic                  mem_lb,
  input  logic                  mem_lh,
  output logic [31:0]           mem_read_data,
  input  logic                  init_wr,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [31:0]           init_data,
  output logic [2:0]            stq_count,
  output logic                  mem_err
);
  localparam int NWORDS = 1 << ADDR_WIDTH;

  logic [31:0]           dmem_q [NWORDS];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  addr_unused;
  logic [31:0]           st_data;
  logic [3:0]            st_be;
  logic                  st_misalign;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_idx;
  logic [31:0]           arr_data;
  logic [3:0]            arr_be;
  logic [31:0]           merged;
  logic                  err_q, err_d;

  assign word_idx    = mem_addr[ADDR_WIDTH+1:2];
  assign addr_unused = ^mem_addr[31:ADDR_WIDTH+2];

  // Big-endian lanes: be[3] is byte offset 0, i.e. bits [31:24].
  always_comb begin
    st_data     = mem_write_data;
    st_be       = 4'b1111;
    st_misalign = 1'b0;
    if (mem_sb) begin
      st_data = {4{mem_write_data[7:0]}};
      st_be   = 4'b1000 >> mem_addr[1:0];
    end else if (mem_sh) begin
      st_data     = {2{mem_write_data[15:0]}};
      st_be       = mem_addr[1] ? 4'b0011 : 4'b1100;
      st_misalign = mem_addr[0];
    end else begin
      st_misalign = |mem_addr[1:0];
    end
  end

`ifdef DMEM_STQ_EN
  logic [ADDR_WIDTH-1:0] stq_idx_q  [STQ_DEPTH];
  logic [ADDR_WIDTH-1:0] stq_idx_d  [STQ_DEPTH];
  logic [31:0]           stq_data_q [STQ_DEPTH];
  logic [31:0]           stq_data_d [STQ_DEPTH];
  logic [3:0]            stq_be_q   [STQ_DEPTH];
  logic [3:0]            stq_be_d   [STQ_DEPTH];
  logic [2:0]            count_q, count_d;
  logic [2:0]            wr_slot;
  logic                  full, deq, enq;

  // Entry 0 is the oldest; a dequeue shifts everything down one slot.
  always_comb begin
    full       = (count_q == 3'(STQ_DEPTH));
    deq        = !init_wr && (count_q != 3'd0);
    enq        = mem_wr && (!full || deq);
    wr_slot    = count_q - {2'b00, deq};
    stq_idx_d  = stq_idx_q;
    stq_data_d = stq_data_q;
    stq_be_d   = stq_be_q;
    if (deq) begin
      for (int i = 0; i < STQ_DEPTH - 1; i++) begin
        stq_idx_d[i]  = stq_idx_q[i+1];
        stq_data_d[i] = stq_data_q[i+1];
        stq_be_d[i]   = stq_be_q[i+1];
      end
    end
    for (int i = 0; i < STQ_DEPTH; i++) begin
      if (enq && wr_slot == 3'(i)) begin
        stq_idx_d[i]  = word_idx;
        stq_data_d[i] = st_data;
        stq_be_d[i]   = st_be;
      end
    end
    count_d  = count_q + {2'b00, enq} - {2'b00, deq};
    err_d    = err_q | (mem_wr & st_misalign) | (mem_wr & !enq);
    arr_we   = init_wr | deq;
    arr_idx  = init_wr ? init_addr : stq_idx_q[0];
    arr_data = init_wr ? init_data : stq_data_q[0];
    arr_be   = init_wr ? 4'b1111   : stq_be_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 3'd0;
    end else begin
      count_q    <= count_d;
      stq_idx_q  <= stq_idx_d;
      stq_data_q <= stq_data_d;
      stq_be_q   <= stq_be_d;
    end
  end

  // Oldest to youngest so the most recent store wins each lane.
  always_comb begin
    merged = dmem_q[word_idx];
    for (int i = 0; i < STQ_DEPTH; i++) begin
      if (3'(i) < count_q && stq_idx_q[i] == word_idx) begin
        for (int b = 0; b < 4; b++) begin
          if (stq_be_q[i][b]) merged[b*8 +: 8] = stq_data_q[i][b*8 +: 8];
        end
      end
    end
  end

  assign stq_count = count_q;
`else
  always_comb begin
    err_d    = err_q | (mem_wr & (init_wr | st_misalign));
    arr_we   = init_wr | mem_wr;
    arr_idx  = init_wr ? init_addr : word_idx;
    arr_data = init_wr ? init_data : st_data;
    arr_be   = init_wr ? 4'b1111   : st_be;
    merged   = dmem_q[word_idx];
  end

  assign stq_count = 3'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && arr_we) begin
      for (int b = 0; b < 4; b++) begin
        if (arr_be[b]) dmem_q[arr_idx][b*8 +: 8] <= arr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    mem_read_data = merged;
    if (mem_lb) begin
      case (mem_addr[1:0])
        2'd0:    mem_read_data = {24'b0, merged[31:24]};
        2'd1:    mem_read_data = {24'b0, merged[23:16]};
        2'd2:    mem_read_data = {24'b0, merged[15:8]};
        default: mem_read_data = {24'b0, merged[7:0]};
      endcase
    end else if (mem_lh) begin
      mem_read_data = mem_addr[1] ? {16'b0, merged[15:0]} : {16'b0, merged[31:16]};
    end
  end

  assign mem_err = err_q;
endmodule

// File: tb/tb_dlx_data_mem.sv
// tb/tb_dlx_data_mem.sv - self-checking bench for dlx_data_mem (queued or direct-store build).
module tb_dlx_data_mem;
  localparam int AW = 10;
`ifdef DMEM_STQ_EN
  localparam bit STQ = 1'b1;
`else
  localparam bit STQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   mem_addr, mem_write_data, mem_read_data, init_data;
  logic          mem_wr, mem_sb, mem_sh, mem_lb, mem_lh, init_wr, mem_err;
  logic [AW-1:0] init_addr;
  logic [2:0]    stq_count;

  always #5 clk = ~clk;

  dlx_data_mem #(.ADDR_WIDTH(AW), .STQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_wr(mem_wr), .mem_sb(mem_sb), .mem_sh(mem_sh), .mem_lb(mem_lb), .mem_lh(mem_lh),
    .mem_read_data(mem_read_data), .init_wr(init_wr), .init_addr(init_addr),
    .init_data(init_data), .stq_count(stq_count), .mem_err(mem_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic preload(input logic [AW-1:0] idx, input logic [31:0] d);
    init_wr = 1'b1; init_addr = idx; init_data = d;
    step();
    init_wr = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic sb, input logic sh);
    mem_addr = a; mem_write_data = d; mem_sb = sb; mem_sh = sh;
    mem_lb = 1'b0; mem_lh = 1'b0; mem_wr = 1'b1;
    step();
    mem_wr = 1'b0; mem_sb = 1'b0; mem_sh = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic lb, input logic lh,
                      input logic [31:0] exp);
    exp_t e;
    mem_wr = 1'b0; mem_addr = a; mem_lb = lb; mem_lh = lh;
    e.tag = tag; e.val = exp;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
    mem_lb = 1'b0; mem_lh = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, mem_read_data, e.val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    reset = 1'b1; mem_addr = '0; mem_write_data = '0; mem_wr = 1'b0;
    mem_sb = 1'b0; mem_sh = 1'b0; mem_lb = 1'b0; mem_lh = 1'b0;
    init_wr = 1'b0; init_addr = '0; init_data = '0;
    idle(2);
    reset = 1'b0;
    check_eq("rst_count", 32'(stq_count), 32'd0);
    check_eq("rst_err", 32'(mem_err), 32'd0);

    preload(AW'(5), 32'h11223344);
    load("t1_lb", 32'h16, 1'b1, 1'b0, 32'h00000033);
    load("t1_lh", 32'h14, 1'b0, 1'b1, 32'h00001122);
    step();

    store(32'h15, 32'h000000AB, 1'b1, 1'b0);
    check_eq("t2_count_pend", 32'(stq_count), STQ ? 32'd1 : 32'd0);
    load("t2_fwd", 32'h14, 1'b0, 1'b0, 32'h11AB3344);
    step();
    check_eq("t2_count_drained", 32'(stq_count), 32'd0);
    load("t2_array", 32'h14, 1'b0, 1'b0, 32'h11AB3344);
    step();
    check_eq("t2_err", 32'(mem_err), 32'd0);

    preload(AW'(0), 32'hCAFE0000);
    init_wr = 1'b1; init_addr = AW'(100); init_data = 32'h0;
    for (int i = 1; i <= 4; i++) store(32'h0, 32'(i), 1'b0, 1'b0);
    check_eq("t3_count_full", 32'(stq_count), STQ ? 32'd4 : 32'd0);
    check_eq("t3_err_before", 32'(mem_err), STQ ? 32'd0 : 32'd1);
    load("t3_youngest", 32'h0, 1'b0, 1'b0, STQ ? 32'd4 : 32'hCAFE0000);
    store(32'h0, 32'd5, 1'b0, 1'b0);
    check_eq("t3_count_drop", 32'(stq_count), STQ ? 32'd4 : 32'd0);
    check_eq("t3_err_drop", 32'(mem_err), 32'd1);
    init_wr = 1'b0;
    idle(4);
    check_eq("t3_count_empty", 32'(stq_count), 32'd0);
    load("t3_drained", 32'h0, 1'b0, 1'b0, STQ ? 32'd4 : 32'hCAFE0000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t3_err_cleared", 32'(mem_err), 32'd0);

    init_wr = 1'b1; init_addr = AW'(100); init_data = 32'h0;
    for (int i = 0; i < 4; i++) store(32'hC, 32'h10 + 32'(i), 1'b0, 1'b0);
    check_eq("t4_count_full", 32'(stq_count), STQ ? 32'd4 : 32'd0);
    init_wr = 1'b0;
    store(32'hC, 32'h14, 1'b0, 1'b0);
    check_eq("t4_count_same", 32'(stq_count), STQ ? 32'd4 : 32'd0);
    check_eq("t4_err", 32'(mem_err), STQ ? 32'd0 : 32'd1);
    idle(4);
    check_eq("t4_count_empty", 32'(stq_count), 32'd0);
    load("t4_last", 32'hC, 1'b0, 1'b0, 32'h00000014);
    reset = 1'b1;
    step();
    reset = 1'b0;

    preload(AW'(8), 32'h01020304);
    store(32'h21, 32'h0000BEEF, 1'b0, 1'b1);
    check_eq("t5_err_set", 32'(mem_err), 32'd1);
    load("t5_lh_hi", 32'h20, 1'b0, 1'b1, 32'h0000BEEF);
    load("t5_lb_3", 32'h23, 1'b1, 1'b0, 32'h00000004);
    store(32'h20, 32'h77777777, 1'b0, 1'b0);
    reset = 1'b1;
    load("t5_fwd", 32'h20, 1'b0, 1'b0, 32'h77777777);
    step();
    reset = 1'b0;
    check_eq("t5_rst_err", 32'(mem_err), 32'd0);
    check_eq("t5_rst_count", 32'(stq_count), 32'd0);
    load("t5_kept", 32'h20, 1'b0, 1'b0, STQ ? 32'hBEEF0304 : 32'h77777777);
    step();

    store((32'd4 << AW) + 32'd8, 32'hDEADBEEF, 1'b0, 1'b0);
    load("t6_wrap", 32'h8, 1'b0, 1'b0, 32'hDEADBEEF);
    step();
    w = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++)
      load($sformatf("t6_lb%0d", i), 32'h8 + 32'(i), 1'b1, 1'b0, (w >> (8 * (3 - i))) & 32'hFF);
    load("t6_lh0", 32'h8, 1'b0, 1'b1, 32'h0000DEAD);
    load("t6_lh1", 32'hA, 1'b0, 1'b1, 32'h0000BEEF);
    step();
    check_eq("t6_err", 32'(mem_err), 32'd0);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
